inv_key_expand: RTL
===================

INV_KEY_EXPAND -- requirements
Module: inv_key_expand

Interface
REQ-001 SHALL have parameter: SIZE, 128, key size in bits; only 128 is legal, other values are an elaboration error.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin inverse expansion.
REQ-005 SHALL have port: key_in  input  128  last (round-10) round key, w40 in [127:96] through w43 in [31:0], sampled with start.
REQ-006 SHALL have port: key_ready  input  1  consumer accepts key_out this cycle.
REQ-007 SHALL have port: key_out  output  128  current round key, same word order as key_in.
REQ-008 SHALL have port: key_valid  output  1  key_out and round_idx are valid.
REQ-009 SHALL have port: round_idx  output  4  round number of key_out, 10 down to 0.
REQ-010 SHALL have port: busy  output  1  high from accepted start until after round 0 is accepted.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after round-0 key is accepted.

Function
REQ-012 SHALL implement FSM states IDLE and EMIT.
REQ-013 IDLE: start=1 -> latch key_in into key register, round counter=10, go to EMIT; start=0 -> stay.
REQ-014 Latency: start sampled at edge N -> key_valid=1, round_idx=10, key_out=key_in after edge N+1.
REQ-015 EMIT: key_valid=1; key_out, round_idx held stable while key_ready=0 (no loss, no change).
REQ-016 EMIT with key_ready=1 and round>0: key register <= previous round key, round decrements by 1, stay EMIT.
REQ-017 EMIT with key_ready=1 and round=0: go IDLE, key_valid=0 next cycle, done=1 for exactly that next cycle.
REQ-018 Previous key from words w0..w3 (w0 = [127:96]): p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^Rcon(round).
REQ-019 RotWord SHALL be a left rotate by one byte; SubWord SHALL apply the AES forward S-box per byte.
REQ-020 Rcon(r) for r=10..1 SHALL be 36,1b,80,40,20,10,08,04,02,01 (hex) in the top byte, lower 24 bits zero.
REQ-021 start while busy=1 SHALL be ignored; no state change.
REQ-022 start in the same cycle done=1 (state IDLE) SHALL be accepted normally.
REQ-023 busy SHALL equal (state==EMIT).
REQ-024 Exactly 11 key_valid&&key_ready transfers per accepted start, round_idx strictly 10..0.
REQ-025 All next-key logic SHALL complete within one cycle; throughput one key per cycle with key_ready held high.

Reset
REQ-026 rst=1 at any edge -> state IDLE; key_out=0, key_valid=0, round_idx=0, busy=0, done=0.
REQ-027 rst SHALL override start and key_ready in the same cycle; reset mid-EMIT aborts with no done pulse.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding, the Rcon table constant, and NR=10.
REQ-029 SHALL instantiate sub-module aes_sbox (8-bit in, 8-bit out, combinational) four times for SubWord.
REQ-030 RotWord and Rcon selection SHALL be inline logic; no memories, no additional clocks.

Verification
REQ-031 Reset then start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 -> round 10 = key_in, round 9 = ac7766f319fadc2128d12941575c006e.
REQ-032 Same run -> round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c, done pulse one cycle later, 11 transfers total.
REQ-033 key_ready toggled randomly during same run -> identical key sequence; key_out/round_idx stable during every key_ready=0 cycle.
REQ-034 start pulsed with different key_in at round 5 -> ignored; sequence continues unchanged.
REQ-035 rst asserted at round 4 -> next cycle all outputs zero, no done; new start restarts at round 10.
REQ-036 start asserted in done cycle -> round-10 key of new run valid on the following cycle.

Source files
------------

// File: rtl/inv_key_expand_pkg.sv
// Shared definitions for the AES-128 inverse key expansion block.
// Holds the FSM state encoding, round count, datapath widths and the Rcon table.
package inv_key_expand_pkg;

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned NR     = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Round constants indexed by round number; entry 0 is unused.
  localparam logic [10:0][7:0] RCON_TBL = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10,
    8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  // Rcon word for a round: constant in the top byte, lower 24 bits zero.
  function automatic logic [WORD_W-1:0] rcon_word(input logic [RND_W-1:0] rnd);
    logic [WORD_W-1:0] w;
    w = '0;
    if ((rnd >= RND_W'(1)) && (rnd <= RND_W'(NR))) begin
      w = {RCON_TBL[rnd], 24'h000000};
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
// Ports: i_byte   - input byte
//        o_byte_c - substituted byte (combinational)
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte_c
);

  // Element 0 sits in the leftmost byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte_c = SBOX[i_byte];

endmodule

// File: rtl/inv_key_expand.sv
// AES-128 inverse key expansion: from the round-10 key, emits round keys
// 10 down to 0 over a valid/ready handshake, one key per cycle at full rate.
// Ports: clk, rst        - clock, synchronous active-high reset
//        start, key_in   - request + round-10 key (w40 in [127:96])
//        key_ready       - consumer accepts key_out this cycle
//        key_out         - current round key
//        key_valid       - key_out/round_idx valid
//        round_idx       - round number of key_out
//        busy            - expansion in progress
//        done            - one-cycle pulse after round 0 is accepted
module inv_key_expand
  import inv_key_expand_pkg::*;
#(
  parameter int unsigned SIZE = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               key_ready,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic [RND_W-1:0]   round_idx,
  output logic               busy,
  output logic               done
);

  // Only AES-128 is supported.
  generate
    if (SIZE != 128) begin : g_bad_size
      $error("inv_key_expand: SIZE must be 128");
    end
  endgenerate

  state_t              r_state;
  logic [KEY_W-1:0]    r_key;
  logic [RND_W-1:0]    r_round;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [KEY_W-1:0]    w_key_nxt;
  logic [RND_W-1:0]    w_round_nxt;
  logic                w_done_nxt;

  logic [WORD_W-1:0]   w_w0, w_w1, w_w2, w_w3;
  logic [WORD_W-1:0]   w_p0, w_p1, w_p2, w_p3;
  logic [WORD_W-1:0]   w_rot;
  logic [WORD_W-1:0]   w_sub;
  logic [KEY_W-1:0]    w_prev_key;

  // Previous round key: undo the word chaining, then recover w[i-4] for the
  // first word using the g() function applied to the already-recovered p3.
  assign w_w0  = r_key[127:96];
  assign w_w1  = r_key[95:64];
  assign w_w2  = r_key[63:32];
  assign w_w3  = r_key[31:0];

  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte   (w_rot[g*BYTE_W +: BYTE_W]),
      .o_byte_c (w_sub[g*BYTE_W +: BYTE_W])
    );
  end

  assign w_p0       = w_w0 ^ w_sub ^ rcon_word(r_round);
  assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

  // Next-state and next-datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_round_nxt = r_round;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_key_nxt   = key_in;
          w_round_nxt = RND_W'(NR);
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (key_ready) begin
          if (r_round == '0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_key_nxt   = w_prev_key;
            w_round_nxt = r_round - RND_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_round <= w_round_nxt;
      r_valid <= (w_state_nxt == ST_EMIT);
      r_busy  <= (w_state_nxt == ST_EMIT);
      r_done  <= w_done_nxt;
    end
  end

  assign key_out   = r_key;
  assign key_valid = r_valid;
  assign round_idx = r_round;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
